branch_con_unit: RTL and testbench

BRANCH_CON_UNIT -- requirements
Module: branch_con_unit

---
 rtl/branch_con_unit_if.sv | 27 ++
 rtl/branch_con_unit.sv | 121 ++++++++++++
 tb/tb_branch_con_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_con_unit_if.sv
// Control-unit <-> branch condition unit bundle: evaluation request, operands,
// and the resulting CON flag with its statistics.
interface branch_con_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             CONin;
  logic             clr_con;
  logic [3:0]       C2;
  logic [WIDTH-1:0] Ra;
  logic [WIDTH-1:0] Rb;
  logic             CON;
  logic             con_valid;
  logic             busy;
  logic [CNT_W-1:0] eval_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output CONin, clr_con, C2, Ra, Rb,
    input  CON, con_valid, busy, eval_cnt, taken_cnt
  );

  modport slave (
    input  CONin, clr_con, C2, Ra, Rb,
    output CON, con_valid, busy, eval_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_con_unit.sv
// Branch condition evaluator: decodes C2 against Ra/Rb through an IDLE/CAPT/EVAL
// sequence and keeps saturating counts of evaluations and taken branches.
module branch_con_unit #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16,
  parameter int REG_IN = 1
) (
  input  logic         clk,
  input  logic         reset,
  branch_con_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPT, EVAL} state_t;

  state_t                  state;
  logic [3:0]              c2_p1;
  logic signed [WIDTH-1:0] ra_p1;
  logic signed [WIDTH-1:0] rb_p1;
  logic                    con;
  logic                    con_valid;
  logic                    busy;
  logic [CNT_W-1:0]        eval_cnt;
  logic [CNT_W-1:0]        taken_cnt;
  logic                    result;

  function automatic logic cond_eval(input logic [3:0] c,
                                     input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b);
    logic r;
    r = 1'b0;
    case (c)
      4'd0:    r = (a == '0);
      4'd1:    r = (a != '0);
      4'd2:    r = !a[WIDTH-1] && (a != '0);
      4'd3:    r = a[WIDTH-1];
      4'd4:    r = !a[WIDTH-1];
      4'd5:    r = a[WIDTH-1] || (a == '0);
      4'd6:    r = 1'b1;
      4'd8:    r = (a == b);
      4'd9:    r = (a != b);
      4'd10:   r = (a < b);
      4'd11:   r = (a >= b);
      4'd12:   r = ($unsigned(a) < $unsigned(b));
      4'd13:   r = ($unsigned(a) >= $unsigned(b));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign result = cond_eval(c2_p1, ra_p1, rb_p1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      c2_p1     <= '0;
      ra_p1     <= '0;
      rb_p1     <= '0;
      con       <= 1'b0;
      con_valid <= 1'b0;
      busy      <= 1'b0;
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else begin
      con_valid <= 1'b0;
      // A clear wins over both a completing evaluation and a new request.
      if (bus.clr_con) begin
        state <= IDLE;
        con   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.CONin) begin
              busy <= 1'b1;
              if (REG_IN != 0) begin
                state <= CAPT;
              end else begin
                state <= EVAL;
                c2_p1 <= bus.C2;
                ra_p1 <= bus.Ra;
                rb_p1 <= bus.Rb;
              end
            end
          end
          // p0 -> p1: operand capture stage
          CAPT: begin
            c2_p1 <= bus.C2;
            ra_p1 <= bus.Ra;
            rb_p1 <= bus.Rb;
            state <= EVAL;
          end
          // p1 -> CON: evaluate and publish
          EVAL: begin
            con       <= result;
            con_valid <= 1'b1;
            eval_cnt  <= sat_inc(eval_cnt);
            if (result) taken_cnt <= sat_inc(taken_cnt);
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.CON       = con;
  assign bus.con_valid = con_valid;
  assign bus.busy      = busy;
  assign bus.eval_cnt  = eval_cnt;
  assign bus.taken_cnt = taken_cnt;

endmodule

// File: tb/tb_branch_con_unit.sv
// Directed bench for branch_con_unit: three instances (registered, direct,
// narrow counters) share one stimulus stream; expectations are hand-computed.
module tb_branch_con_unit;

  logic        clk;
  logic        reset;
  logic        conin;
  logic        clr;
  logic [3:0]  c2;
  logic [31:0] ra;
  logic [31:0] rb;

  int checks = 0;
  int errors = 0;
  int exp_eval;
  int exp_taken;

  typedef struct {
    logic [3:0]  c2;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        exp;
  } vec_t;
  vec_t vecs[15];

  branch_con_unit_if #(.WIDTH(32), .CNT_W(16)) if_a ();
  branch_con_unit_if #(.WIDTH(32), .CNT_W(16)) if_b ();
  branch_con_unit_if #(.WIDTH(32), .CNT_W(2))  if_c ();

  assign if_a.CONin = conin;  assign if_a.clr_con = clr;
  assign if_a.C2 = c2;        assign if_a.Ra = ra;  assign if_a.Rb = rb;
  assign if_b.CONin = conin;  assign if_b.clr_con = clr;
  assign if_b.C2 = c2;        assign if_b.Ra = ra;  assign if_b.Rb = rb;
  assign if_c.CONin = conin;  assign if_c.clr_con = clr;
  assign if_c.C2 = c2;        assign if_c.Ra = ra;  assign if_c.Rb = rb;

  branch_con_unit #(.WIDTH(32), .CNT_W(16), .REG_IN(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  branch_con_unit #(.WIDTH(32), .CNT_W(16), .REG_IN(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  branch_con_unit #(.WIDTH(32), .CNT_W(2),  .REG_IN(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request an evaluation; returns just after the edge that publishes dut_a's result.
  task automatic fire(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    c2 = c; ra = a; rb = b;
    conin = 1'b1;
    tick();
    conin = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0]  = '{4'd10, 32'hFFFF_FFFF, 32'd1,       1'b1};
    vecs[1]  = '{4'd12, 32'hFFFF_FFFF, 32'd1,       1'b0};
    vecs[2]  = '{4'd3,  32'h8000_0000, 32'd0,       1'b1};
    vecs[3]  = '{4'd2,  32'd0,         32'd0,       1'b0};
    vecs[4]  = '{4'd2,  32'd5,         32'd0,       1'b1};
    vecs[5]  = '{4'd5,  32'd0,         32'd0,       1'b1};
    vecs[6]  = '{4'd4,  32'h8000_0000, 32'd0,       1'b0};
    vecs[7]  = '{4'd1,  32'd7,         32'd0,       1'b1};
    vecs[8]  = '{4'd8,  32'h1234,      32'h1234,    1'b1};
    vecs[9]  = '{4'd9,  32'h1234,      32'h1234,    1'b0};
    vecs[10] = '{4'd13, 32'd5,         32'd5,       1'b1};
    vecs[11] = '{4'd11, 32'h8000_0000, 32'd0,       1'b0};
    vecs[12] = '{4'd7,  32'd0,         32'd0,       1'b0};
    vecs[13] = '{4'd14, 32'd0,         32'd0,       1'b0};
    vecs[14] = '{4'd15, 32'd0,         32'd0,       1'b0};

    reset = 1'b0; conin = 1'b0; clr = 1'b0; c2 = '0; ra = '0; rb = '0;
    #12;
    check("rst_con",   if_a.CON, 0);
    check("rst_valid", if_a.con_valid, 0);
    check("rst_busy",  if_a.busy, 0);
    check("rst_eval",  if_a.eval_cnt, 0);
    check("rst_taken", if_a.taken_cnt, 0);
    tick();
    reset = 1'b1;

    // Basic REG_IN=1 latency with C2=0, Ra=0
    c2 = 4'd0; ra = '0; rb = '0;
    conin = 1'b1;
    tick();
    conin = 1'b0;
    check("lat_busy_n",   if_a.busy, 1);
    check("lat_valid_n",  if_a.con_valid, 0);
    tick();
    check("lat_busy_n1",  if_a.busy, 1);
    check("lat_valid_n1", if_a.con_valid, 0);
    check("lat_con_n1",   if_a.CON, 0);
    tick();
    check("lat_con_n2",   if_a.CON, 1);
    check("lat_valid_n2", if_a.con_valid, 1);
    check("lat_busy_n2",  if_a.busy, 0);
    check("lat_eval",     if_a.eval_cnt, 1);
    check("lat_taken",    if_a.taken_cnt, 1);
    tick();
    check("hold_valid",   if_a.con_valid, 0);
    check("hold_con",     if_a.CON, 1);

    // Saturation of the 2-bit counters
    for (int i = 0; i < 3; i++) fire(4'd6, '0, '0);
    check("sat_eval_c",  if_c.eval_cnt, 3);
    check("sat_taken_c", if_c.taken_cnt, 3);
    check("sat_eval_a",  if_a.eval_cnt, 4);
    exp_eval = 4;
    exp_taken = 4;

    // Condition decode table
    for (int i = 0; i < 15; i++) begin
      fire(vecs[i].c2, vecs[i].ra, vecs[i].rb);
      exp_eval++;
      if (vecs[i].exp) exp_taken++;
      check($sformatf("vec%0d_con", i), if_a.CON, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), if_a.con_valid, 1);
      check($sformatf("vec%0d_eval", i), if_a.eval_cnt, exp_eval);
      check($sformatf("vec%0d_taken", i), if_a.taken_cnt, exp_taken);
    end

    // CONin held into the busy window is not queued
    c2 = 4'd6;
    conin = 1'b1;
    tick();
    tick();
    conin = 1'b0;
    tick();
    exp_eval++;
    exp_taken++;
    check("nq_valid", if_a.con_valid, 1);
    check("nq_eval",  if_a.eval_cnt, exp_eval);
    tick();
    check("nq_valid2", if_a.con_valid, 0);
    check("nq_busy",   if_a.busy, 0);
    tick();
    check("nq_eval2",  if_a.eval_cnt, exp_eval);

    // clr_con during EVAL aborts the evaluation
    c2 = 4'd6;
    conin = 1'b1;
    tick();
    conin = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_con",   if_a.CON, 0);
    check("clr_valid", if_a.con_valid, 0);
    check("clr_busy",  if_a.busy, 0);
    check("clr_eval",  if_a.eval_cnt, exp_eval);
    check("clr_taken", if_a.taken_cnt, exp_taken);
    tick();
    check("clr_valid2", if_a.con_valid, 0);

    // clr_con beats a simultaneous CONin
    fire(4'd6, '0, '0);
    exp_eval++;
    exp_taken++;
    check("pre_clr_con", if_a.CON, 1);
    clr = 1'b1;
    conin = 1'b1;
    tick();
    clr = 1'b0;
    conin = 1'b0;
    check("clrin_busy", if_a.busy, 0);
    check("clrin_con",  if_a.CON, 0);
    tick();
    tick();
    check("clrin_valid", if_a.con_valid, 0);
    check("clrin_eval",  if_a.eval_cnt, exp_eval);

    // Asynchronous reset in CAPT, then REG_IN=0 latency
    fire(4'd6, '0, '0);
    check("pre_rst_con", if_a.CON, 1);
    conin = 1'b1;
    tick();
    conin = 1'b0;
    check("capt_busy", if_a.busy, 1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_con",   if_a.CON, 0);
    check("arst_busy",  if_a.busy, 0);
    check("arst_valid", if_a.con_valid, 0);
    check("arst_eval",  if_a.eval_cnt, 0);
    check("arst_taken", if_a.taken_cnt, 0);
    check("arst_con_b", if_b.CON, 0);
    #2;
    reset = 1'b1;
    c2 = 4'd6;
    conin = 1'b1;
    tick();
    conin = 1'b0;
    check("d_busy_b",  if_b.busy, 1);
    check("d_con_b",   if_b.CON, 0);
    check("d_busy_a",  if_a.busy, 1);
    tick();
    check("d_con_b1",   if_b.CON, 1);
    check("d_valid_b1", if_b.con_valid, 1);
    check("d_busy_b1",  if_b.busy, 0);
    check("d_eval_b1",  if_b.eval_cnt, 1);
    check("d_taken_b1", if_b.taken_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
